// File: rtl/uart_imem_loader.sv
// ============================================================================
// Module   : uart_imem_loader
// Brief    : UART (8N1) boot loader that writes a framed program image into
//            instruction memory and holds the core in reset until it is done.
//            Optional checksum byte enabled by defining UART_LOADER_CSUM_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module uart_imem_loader #(
    parameter int CLK_HZ       = 50_000_000,
    parameter int BAUD         = 115200,
    parameter int IMEM_WORDS   = 256,
    parameter int TIMEOUT_BITS = 64
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        uart_rx,
    output logic        imem_we,
    output logic [31:0] imem_waddr,
    output logic [31:0] imem_wdata,
    output logic        cpu_rst,
    output logic        loading,
    output logic        err,
    output logic [15:0] word_count
);

    localparam int          CLKS_PER_BIT = CLK_HZ / BAUD;
    localparam logic [15:0] BIT_LAST     = 16'(CLKS_PER_BIT - 1);
    localparam logic [15:0] HALF_LAST    = 16'(CLKS_PER_BIT / 2 - 1);
    localparam logic [31:0] TO_LAST      = 32'(TIMEOUT_BITS * CLKS_PER_BIT - 1);
    localparam logic [16:0] MAX_LEN      = 17'(IMEM_WORDS);
    localparam logic [7:0]  SYNC_BYTE    = 8'hA5;

    typedef enum logic [1:0] {
        RX_IDLE,
        RX_START,
        RX_DATA,
        RX_STOP
    } rx_state_t;

    typedef enum logic [2:0] {
        F_IDLE,
        F_LEN0,
        F_LEN1,
        F_DATA,
`ifdef UART_LOADER_CSUM_EN
        F_CSUM,
`endif
        F_DONE
    } frame_state_t;

    rx_state_t    r_rx_state;
    frame_state_t r_fstate;

    logic        r_rx_meta;
    logic        r_rx_sync;
    logic        r_rx_d;
    logic [15:0] r_bit_cnt;
    logic [2:0]  r_bit_idx;
    logic [7:0]  r_shreg;
    logic        r_byte_valid;
    logic        r_stop_err;

    logic [15:0] r_len;
    logic [31:0] r_addr;
    logic [23:0] r_word;
    logic [1:0]  r_idx;
    logic [31:0] r_to_cnt;
`ifdef UART_LOADER_CSUM_EN
    logic [7:0]  r_csum;
`endif

    logic [15:0] w_len_full;
    logic        w_last_word;
    logic        w_in_frame;

    assign w_len_full  = {r_shreg, r_len[7:0]};
    assign w_last_word = ((word_count + 16'd1) == r_len);
    assign w_in_frame  = (r_fstate != F_IDLE) && (r_fstate != F_DONE);

    // Receiver: start bit is re-checked at half a bit, data/stop at mid-bit.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_rx_meta    <= 1'b1;
            r_rx_sync    <= 1'b1;
            r_rx_d       <= 1'b1;
            r_rx_state   <= RX_IDLE;
            r_bit_cnt    <= 16'd0;
            r_bit_idx    <= 3'd0;
            r_shreg      <= 8'd0;
            r_byte_valid <= 1'b0;
            r_stop_err   <= 1'b0;
        end else begin
            r_rx_meta    <= uart_rx;
            r_rx_sync    <= r_rx_meta;
            r_rx_d       <= r_rx_sync;
            r_byte_valid <= 1'b0;
            r_stop_err   <= 1'b0;
            case (r_rx_state)
                RX_IDLE: begin
                    if (r_rx_d && !r_rx_sync) begin
                        r_rx_state <= RX_START;
                        r_bit_cnt  <= 16'd0;
                    end
                end
                RX_START: begin
                    if (r_bit_cnt == HALF_LAST) begin
                        r_bit_cnt <= 16'd0;
                        r_bit_idx <= 3'd0;
                        r_rx_state <= r_rx_sync ? RX_IDLE : RX_DATA;
                    end else begin
                        r_bit_cnt <= r_bit_cnt + 16'd1;
                    end
                end
                RX_DATA: begin
                    if (r_bit_cnt == BIT_LAST) begin
                        r_bit_cnt <= 16'd0;
                        r_shreg   <= {r_rx_sync, r_shreg[7:1]};
                        if (r_bit_idx == 3'd7) begin
                            r_rx_state <= RX_STOP;
                        end else begin
                            r_bit_idx <= r_bit_idx + 3'd1;
                        end
                    end else begin
                        r_bit_cnt <= r_bit_cnt + 16'd1;
                    end
                end
                RX_STOP: begin
                    if (r_bit_cnt == BIT_LAST) begin
                        r_bit_cnt    <= 16'd0;
                        r_rx_state   <= RX_IDLE;
                        r_byte_valid <= r_rx_sync;
                        r_stop_err   <= !r_rx_sync;
                    end else begin
                        r_bit_cnt <= r_bit_cnt + 16'd1;
                    end
                end
                default: r_rx_state <= RX_IDLE;
            endcase
        end
    end

    // Frame decoder; all outputs registered so they change the cycle after byte_valid.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_fstate   <= F_IDLE;
            r_len      <= 16'd0;
            r_addr     <= 32'd0;
            r_word     <= 24'd0;
            r_idx      <= 2'd0;
            r_to_cnt   <= 32'd0;
`ifdef UART_LOADER_CSUM_EN
            r_csum     <= 8'd0;
`endif
            imem_we    <= 1'b0;
            imem_waddr <= 32'd0;
            imem_wdata <= 32'd0;
            cpu_rst    <= 1'b1;
            loading    <= 1'b0;
            err        <= 1'b0;
            word_count <= 16'd0;
        end else begin
            imem_we <= 1'b0;

            if (!w_in_frame || r_byte_valid) begin
                r_to_cnt <= 32'd0;
            end else begin
                r_to_cnt <= r_to_cnt + 32'd1;
            end

            if (r_stop_err) begin
                err <= 1'b1;
                if (w_in_frame) begin
                    r_fstate <= F_IDLE;
                    loading  <= 1'b0;
                end
            end else if (w_in_frame && (r_to_cnt == TO_LAST)) begin
                err      <= 1'b1;
                r_fstate <= F_IDLE;
                loading  <= 1'b0;
            end else if (r_byte_valid) begin
                case (r_fstate)
                    F_IDLE, F_DONE: begin
                        if (r_shreg == SYNC_BYTE) begin
                            r_fstate   <= F_LEN0;
                            cpu_rst    <= 1'b1;
                            loading    <= 1'b1;
                            err        <= 1'b0;
                            word_count <= 16'd0;
                            r_addr     <= 32'd0;
                            r_idx      <= 2'd0;
`ifdef UART_LOADER_CSUM_EN
                            r_csum     <= 8'd0;
`endif
                        end
                    end
                    F_LEN0: begin
                        r_len[7:0] <= r_shreg;
                        r_fstate   <= F_LEN1;
                    end
                    F_LEN1: begin
                        r_len <= w_len_full;
                        if ({1'b0, w_len_full} > MAX_LEN) begin
                            err      <= 1'b1;
                            loading  <= 1'b0;
                            r_fstate <= F_IDLE;
                        end else if (w_len_full == 16'd0) begin
`ifdef UART_LOADER_CSUM_EN
                            r_fstate <= F_CSUM;
`else
                            r_fstate <= F_DONE;
                            cpu_rst  <= 1'b0;
                            loading  <= 1'b0;
`endif
                        end else begin
                            r_fstate <= F_DATA;
                        end
                    end
                    F_DATA: begin
`ifdef UART_LOADER_CSUM_EN
                        r_csum <= r_csum ^ r_shreg;
`endif
                        r_idx  <= r_idx + 2'd1;
                        r_word <= {r_shreg, r_word[23:8]};
                        if (r_idx == 2'd3) begin
                            imem_we    <= 1'b1;
                            imem_waddr <= r_addr;
                            imem_wdata <= {r_shreg, r_word};
                            r_addr     <= r_addr + 32'd4;
                            word_count <= word_count + 16'd1;
                            if (w_last_word) begin
`ifdef UART_LOADER_CSUM_EN
                                r_fstate <= F_CSUM;
`else
                                r_fstate <= F_DONE;
                                cpu_rst  <= 1'b0;
                                loading  <= 1'b0;
`endif
                            end
                        end
                    end
`ifdef UART_LOADER_CSUM_EN
                    F_CSUM: begin
                        loading <= 1'b0;
                        if (r_shreg == r_csum) begin
                            r_fstate <= F_DONE;
                            cpu_rst  <= 1'b0;
                        end else begin
                            r_fstate <= F_IDLE;
                            err      <= 1'b1;
                        end
                    end
`endif
                    default: r_fstate <= F_IDLE;
                endcase
            end
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_uart_imem_loader.sv
// ============================================================================
// Module   : tb_uart_imem_loader
// Brief    : Directed self-checking bench for uart_imem_loader (10 clk/bit).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_uart_imem_loader;

    localparam int CPB = 10;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        uart_rx = 1'b1;
    logic        imem_we;
    logic [31:0] imem_waddr;
    logic [31:0] imem_wdata;
    logic        cpu_rst;
    logic        loading;
    logic        err;
    logic [15:0] word_count;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;
    int t_last_start = 0;
    int t_word0 = 0;
    int fall_cyc = -1;
    logic prev_cpu_rst = 1'b1;
    logic prev_we = 1'b0;
    logic double_we = 1'b0;

    logic [31:0] q_addr[$];
    logic [31:0] q_data[$];
    int          q_cyc[$];

    uart_imem_loader #(
        .CLK_HZ      (1_000_000),
        .BAUD        (100_000),
        .IMEM_WORDS  (256),
        .TIMEOUT_BITS(64)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .uart_rx   (uart_rx),
        .imem_we   (imem_we),
        .imem_waddr(imem_waddr),
        .imem_wdata(imem_wdata),
        .cpu_rst   (cpu_rst),
        .loading   (loading),
        .err       (err),
        .word_count(word_count)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (!rst) begin
            if (imem_we) begin
                q_addr.push_back(imem_waddr);
                q_data.push_back(imem_wdata);
                q_cyc.push_back(cyc);
            end
            if (imem_we && prev_we) double_we = 1'b1;
            if (prev_cpu_rst && !cpu_rst) fall_cyc = cyc;
        end
        prev_we      = imem_we;
        prev_cpu_rst = cpu_rst;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic send_byte(input logic [7:0] b, input logic stop_bit = 1'b1);
        @(posedge clk);
        #1 uart_rx = 1'b0;
        t_last_start = cyc;
        for (int i = 0; i < 8; i++) begin
            repeat (CPB) @(posedge clk);
            #1 uart_rx = b[i];
        end
        repeat (CPB) @(posedge clk);
        #1 uart_rx = stop_bit;
        repeat (CPB) @(posedge clk);
        #1 uart_rx = 1'b1;
    endtask

    task automatic clear_log();
        q_addr.delete();
        q_data.delete();
        q_cyc.delete();
        fall_cyc = -1;
    endtask

    // Two-word program: 0x00500013 then 0x00100093; payload XOR is 0xC0.
    task automatic send_prog(input logic [7:0] csum);
        send_byte(8'hA5); send_byte(8'h02); send_byte(8'h00);
        send_byte(8'h13); send_byte(8'h00); send_byte(8'h50); send_byte(8'h00);
        t_word0 = t_last_start;
        send_byte(8'h93); send_byte(8'h00); send_byte(8'h10); send_byte(8'h00);
`ifdef UART_LOADER_CSUM_EN
        send_byte(csum);
`else
        if (csum != csum) $display("unused");
`endif
        repeat (3) @(posedge clk);
        #1;
    endtask

    task automatic check_writes(input string tag);
        chk({tag, "_nwrites"}, q_addr.size(), 2);
        if (q_addr.size() >= 2) begin
            chk({tag, "_addr0"}, q_addr[0], 32'h0);
            chk({tag, "_data0"}, q_data[0], 32'h00500013);
            chk({tag, "_addr1"}, q_addr[1], 32'h4);
            chk({tag, "_data1"}, q_data[1], 32'h00100093);
        end
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        clear_log();
    endtask

    initial begin
        repeat (4) @(posedge clk);
        #1;
        chk("rst_we", imem_we, 0);
        chk("rst_waddr", imem_waddr, 0);
        chk("rst_wdata", imem_wdata, 0);
        chk("rst_cpu_rst", cpu_rst, 1);
        chk("rst_loading", loading, 0);
        chk("rst_err", err, 0);
        chk("rst_word_count", word_count, 0);
        rst = 1'b0;
        repeat (5) @(posedge clk);

        // Good frame
        clear_log();
        send_prog(8'hC0);
        check_writes("good");
        if (q_cyc.size() >= 1) chk("good_we_latency", q_cyc[0] - t_word0, 99);
        chk("good_word_count", word_count, 2);
        chk("good_err", err, 0);
        chk("good_cpu_rst", cpu_rst, 0);
        chk("good_loading", loading, 0);
        chk("good_cpu_rst_latency", fall_cyc - t_last_start, 99);

`ifdef UART_LOADER_CSUM_EN
        // Bad checksum: words still written, core stays in reset
        clear_log();
        send_prog(8'h00);
        check_writes("badcs");
        chk("badcs_err", err, 1);
        chk("badcs_cpu_rst", cpu_rst, 1);
        chk("badcs_loading", loading, 0);
`endif

        // Oversize length, then a valid reload
        clear_log();
        send_byte(8'hA5); send_byte(8'h01); send_byte(8'h01);
        repeat (20) @(posedge clk);
        #1;
        chk("len_err", err, 1);
        chk("len_nwrites", q_addr.size(), 0);
        chk("len_loading", loading, 0);
        chk("len_cpu_rst", cpu_rst, 1);
        send_prog(8'hC0);
        check_writes("len_reload");
        chk("len_reload_err", err, 0);
        chk("len_reload_cpu_rst", cpu_rst, 0);

        // Framing error on third payload byte
        do_reset();
        send_byte(8'hA5); send_byte(8'h02); send_byte(8'h00);
        send_byte(8'h13); send_byte(8'h00);
        send_byte(8'h50, 1'b0);
        repeat (20) @(posedge clk);
        #1;
        chk("stop_err", err, 1);
        chk("stop_nwrites", q_addr.size(), 0);
        chk("stop_cpu_rst", cpu_rst, 1);
        chk("stop_loading", loading, 0);

        // Mid-frame idle timeout (640 cycles after LEN_HI)
        do_reset();
        send_byte(8'hA5); send_byte(8'h02); send_byte(8'h00);
        repeat (600) @(posedge clk);
        #1;
        chk("to_before_err", err, 0);
        chk("to_before_loading", loading, 1);
        repeat (50) @(posedge clk);
        #1;
        chk("to_after_err", err, 1);
        chk("to_after_loading", loading, 0);

        // Noise bytes and a one-clock glitch before a valid frame
        do_reset();
        send_byte(8'h00); send_byte(8'hFF);
        @(posedge clk);
        #1 uart_rx = 1'b0;
        @(posedge clk);
        #1 uart_rx = 1'b1;
        repeat (40) @(posedge clk);
        #1;
        chk("noise_loading", loading, 0);
        chk("noise_err", err, 0);
        chk("noise_cpu_rst", cpu_rst, 1);
        send_prog(8'hC0);
        check_writes("noise");
        chk("noise_word_count", word_count, 2);
        chk("noise_final_cpu_rst", cpu_rst, 0);

        // Reset in the middle of the payload, then a fresh load
        do_reset();
        send_byte(8'hA5); send_byte(8'h02); send_byte(8'h00);
        send_byte(8'h13); send_byte(8'h00); send_byte(8'h50); send_byte(8'h00);
        send_byte(8'h93);
        chk("mid_word_count", word_count, 1);
        @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1;
        chk("mid_rst_we", imem_we, 0);
        chk("mid_rst_waddr", imem_waddr, 0);
        chk("mid_rst_wdata", imem_wdata, 0);
        chk("mid_rst_cpu_rst", cpu_rst, 1);
        chk("mid_rst_loading", loading, 0);
        chk("mid_rst_err", err, 0);
        chk("mid_rst_word_count", word_count, 0);
        rst = 1'b0;
        clear_log();
        send_prog(8'hC0);
        check_writes("fresh");
        chk("fresh_cpu_rst", cpu_rst, 0);
        chk("fresh_err", err, 0);

        chk("we_single_cycle", double_we, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
